counter_sweep_ctrl: RTL

Sequencer for the N-bit `up_down_counter`. It drives the counter's load, load-value and direction inputs so that the count sweeps back and forth between a lower and an upper bound for a programmed number of passes. While idle, it freezes the counter by reloading a held value every cycle. It sits between a control master (start/abort pulses) and one counter instance, and reads the counter's `count_out` back.

---
 rtl/counter_sweep_ctrl_if.sv | 17 +
 rtl/counter_sweep_ctrl.sv | 83 ++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl_if.sv
// counter_sweep_ctrl_if: control-master bundle (start/abort/lo/hi/passes in; busy/done/err/pass_count out)
interface counter_sweep_ctrl_if #(
  parameter int N = 4,
  parameter int PW = 8
);
  logic start;
  logic abort;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [PW-1:0] passes;
  logic busy;
  logic done;
  logic err;
  logic [PW-1:0] pass_count;
  modport master (output start, abort, lo, hi, passes, input busy, done, err, pass_count);
  modport slave (input start, abort, lo, hi, passes, output busy, done, err, pass_count);
endinterface

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: sweeps an up/down counter between lo and hi for a number of passes; ports clk, rst_n, ctl (control bundle), count_in/carry_in (counter readback), ctr_load/ctr_load_value/ctr_up_down (counter drive)
module counter_sweep_ctrl #(
  parameter int N = 4,
  parameter int PW = 8
) (
  input  logic clk,
  input  logic rst_n,
  counter_sweep_ctrl_if.slave ctl,
  input  logic [N-1:0] count_in,
  input  logic carry_in,
  output logic ctr_load,
  output logic [N-1:0] ctr_load_value,
  output logic ctr_up_down
);
  typedef enum logic [1:0] {IDLE, PRIME, SWEEP} state_t;
  state_t state;
  logic [N-1:0] lo_q, hi_q, hold_q;
  logic [PW-1:0] passes_q, pass_q;
  logic dir_q, busy_q, done_q, err_q;
  logic sweep, turn, last, stop;
  always_comb begin
    sweep = state == SWEEP;
    turn = sweep && count_in == (dir_q ? hi_q : lo_q);
    last = turn && passes_q != '0 && pass_q + PW'(1) == passes_q;
    stop = sweep && (ctl.abort || carry_in);
    ctr_load = !sweep || stop || last;
    ctr_load_value = state == IDLE ? hold_q : state == PRIME ? lo_q : count_in;
    ctr_up_down = !sweep || (dir_q ^ turn);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      hold_q <= '0;
      passes_q <= '0;
      pass_q <= '0;
      dir_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (ctl.start) begin
          if (ctl.lo < ctl.hi) begin
            lo_q <= ctl.lo;
            hi_q <= ctl.hi;
            passes_q <= ctl.passes;
            hold_q <= ctl.lo;
            pass_q <= '0;
            busy_q <= 1'b1;
            state <= PRIME;
          end else err_q <= 1'b1;
        end
        PRIME: begin
          dir_q <= 1'b1;
          state <= SWEEP;
        end
        default: if (stop) begin
          hold_q <= count_in;
          busy_q <= 1'b0;
          err_q <= carry_in;
          state <= IDLE;
        end else if (turn) begin
          pass_q <= pass_q + PW'(1);
          dir_q <= ~dir_q;
          if (last) begin
            hold_q <= count_in;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end
  assign ctl.busy = busy_q;
  assign ctl.done = done_q;
  assign ctl.err = err_q;
  assign ctl.pass_count = pass_q;
endmodule
